// File: rtl/mem_access_unit.sv
// Memory access unit: converts byte/half/word load and store requests into
// aligned word accesses. Sub-word stores use read-modify-write and sub-word
// loads are sign- or zero-extended. Misaligned or reserved-mode requests
// complete with err=1 and never touch memory. Byte lanes are big-endian.
module mem_access_unit #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            mode,
  input  logic                  uns,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [WIDTH-1:0]      rdata,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  MemWrite,
  output logic [1:0]            MemMode,
  output logic [WIDTH-1:0]      memWriteData,
  input  logic [WIDTH-1:0]      memReadData
);

  localparam logic [1:0] MODE_WORD = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_BYTE = 2'b10;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e                  state_q, state_d;
  logic                    we_q, we_d;
  logic [1:0]              mode_q, mode_d;
  logic                    uns_q, uns_d;
  logic [1:0]              off_q, off_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [15:0]             sub_q, sub_d;
  logic [WIDTH-1:0]        wbuf_q, wbuf_d;
  logic [WIDTH-1:0]        rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    misalign;

  // Select the addressed lane (offset 0 = bits 31:24) and extend it
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] m,
                                          input logic [1:0] off, input logic u);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (m)
      MODE_BYTE: r = {{24{~u & b[7]}}, b};
      MODE_HALF: r = {{16{~u & h[15]}}, h};
      default:   r = w;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane of the read word with the store data
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] m,
                                        input logic [1:0] off, input logic [15:0] s);
    logic [31:0] r;
    r = w;
    if (m == MODE_BYTE) begin
      case (off)
        2'd0:    r[31:24] = s[7:0];
        2'd1:    r[23:16] = s[7:0];
        2'd2:    r[15:8]  = s[7:0];
        default: r[7:0]   = s[7:0];
      endcase
    end else if (off[1]) begin
      r[15:0] = s;
    end else begin
      r[31:16] = s;
    end
    return r;
  endfunction

  // Request is rejected for reserved mode or an address not aligned to its size
  always_comb begin
    misalign = (mode == 2'b11) ||
               ((mode == MODE_HALF) && addr[0]) ||
               ((mode == MODE_WORD) && (addr[1:0] != 2'b00));
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      mode_q  <= '0;
      uns_q   <= 1'b0;
      off_q   <= '0;
      addr_q  <= '0;
      sub_q   <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      mode_q  <= mode_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      sub_q   <= sub_d;
      wbuf_q  <= wbuf_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (misalign)                          state_d = DONE;
          else if (!we || (mode != MODE_WORD))   state_d = READ;
          else                                   state_d = WRITE;
        end
      end
      READ:    state_d = we_q ? WRITE : DONE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, load result and merge buffer updates
  always_comb begin
    we_d    = we_q;
    mode_d  = mode_q;
    uns_d   = uns_q;
    off_d   = off_q;
    addr_d  = addr_q;
    sub_d   = sub_q;
    wbuf_d  = wbuf_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if ((state_q == IDLE) && req) begin
      we_d   = we;
      mode_d = mode;
      uns_d  = uns;
      off_d  = addr[1:0];
      addr_d = {addr[ADDR_WIDTH-1:2], 2'b00};
      sub_d  = wdata[15:0];
      err_d  = misalign;
      if (we && (mode == MODE_WORD)) wbuf_d = wdata;
    end else if (state_q == READ) begin
      if (we_q) wbuf_d  = merge(memReadData, mode_q, off_q, sub_q);
      else      rdata_d = extract(memReadData, mode_q, off_q, uns_q);
    end
  end

  // Outputs decoded from state; write strobe is suppressed during reset
  always_comb begin
    busy         = (state_q == READ) || (state_q == WRITE);
    done         = (state_q == DONE);
    err          = (state_q == DONE) && err_q;
    MemWrite     = (state_q == WRITE) && !reset;
    MemMode      = MODE_WORD;
    memAddr      = addr_q;
    memWriteData = wbuf_q;
    rdata        = rdata_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed cases plus randomized requests
// compared against a word-array reference model of memory and load results.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset, req, we, uns;
  logic [1:0]  mode;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic        busy, done, err, MemWrite;
  logic [31:0] rdata, memWriteData, memReadData;
  logic [15:0] memAddr;
  logic [1:0]  MemMode;

  logic [31:0] mem     [0:16383];
  logic [31:0] ref_mem [0:16383];
  logic [31:0] ref_rdata;
  int          pass_cnt = 0;
  int          total    = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.WIDTH(32), .ADDR_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .mode(mode), .uns(uns),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .memAddr(memAddr), .MemWrite(MemWrite), .MemMode(MemMode),
    .memWriteData(memWriteData), .memReadData(memReadData)
  );

  assign memReadData = mem[memAddr[15:2]];
  always @(posedge clk) if (MemWrite) mem[memAddr[15:2]] <= memWriteData;

  task automatic preload(input logic [15:0] a, input logic [31:0] v);
    mem[a[15:2]]     = v;
    ref_mem[a[15:2]] = v;
  endtask

  // Issue one request and check latency, write traffic, result and memory
  task automatic run_op(input string name, input logic w, input logic [1:0] m,
                        input logic u, input logic [15:0] a, input logic [31:0] wd,
                        input bit poke);
    logic [31:0] word, val, new_word, mask, exp_rd;
    bit          bad;
    int          sh, exp_lat, exp_wcyc, dcyc, wcyc, wcount, busy_bad;
    logic        derr;
    logic [31:0] wdat, drd;
    logic [15:0] waddr;
    word     = ref_mem[a[15:2]];
    bad      = (m == 2'b11) || (m == 2'b01 && a[0]) || (m == 2'b00 && a[1:0] != 2'b00);
    sh       = (m == 2'b10) ? 8 * (3 - int'(a[1:0])) : (a[1] ? 0 : 16);
    mask     = (m == 2'b10) ? 32'hFF : 32'hFFFF;
    exp_lat  = bad ? 1 : ((w && m != 2'b00) ? 3 : 2);
    exp_wcyc = (bad || !w) ? 0 : ((m == 2'b00) ? 1 : 2);
    if (m == 2'b00) val = word;
    else begin
      val = (word >> sh) & mask;
      if (!u && (val & ((mask + 1) >> 1)) != 0) val = val | ~mask;
    end
    new_word = (m == 2'b00) ? wd : ((word & ~(mask << sh)) | ((wd & mask) << sh));
    exp_rd   = (!bad && !w) ? val : ref_rdata;

    req = 1'b1; we = w; mode = m; uns = u; addr = a; wdata = wd;
    @(posedge clk); #1;
    req = 1'b0;
    dcyc = 0; wcyc = 0; wcount = 0; busy_bad = 0;
    derr = 1'bx; drd = 'x; wdat = 'x; waddr = 'x;
    for (int c = 1; c <= 8; c++) begin
      if (poke && c == 1) begin
        req = 1'b1; we = 1'b1; mode = 2'b00; addr = 16'h1040; wdata = 32'h5A5A5A5A;
      end
      if (poke && c == 2) req = 1'b0;
      if (MemWrite) begin wcount++; wcyc = c; wdat = memWriteData; waddr = memAddr; end
      if (busy !== !done) busy_bad++;
      if (done === 1'b1) begin dcyc = c; derr = err; drd = rdata; break; end
      @(posedge clk); #1;
    end

    total++;
    if (dcyc !== exp_lat) $display("FAIL %s latency: got %0d want %0d", name, dcyc, exp_lat);
    else pass_cnt++;
    total++;
    if (derr !== bad) $display("FAIL %s err: got %b want %b", name, derr, bad);
    else pass_cnt++;
    total++;
    if (busy_bad != 0) $display("FAIL %s busy: %0d bad cycles want 0", name, busy_bad);
    else pass_cnt++;
    total++;
    if (wcount !== (exp_wcyc != 0 ? 1 : 0) || wcyc !== exp_wcyc)
      $display("FAIL %s memwrite: count %0d cycle %0d want count %0d cycle %0d",
               name, wcount, wcyc, (exp_wcyc != 0 ? 1 : 0), exp_wcyc);
    else pass_cnt++;
    if (exp_wcyc != 0) begin
      total++;
      if (wdat !== new_word || waddr !== {a[15:2], 2'b00})
        $display("FAIL %s wdata: got %h@%h want %h@%h", name, wdat, waddr, new_word, {a[15:2], 2'b00});
      else pass_cnt++;
      ref_mem[a[15:2]] = new_word;
    end
    total++;
    if (drd !== exp_rd) $display("FAIL %s rdata: got %h want %h", name, drd, exp_rd);
    else pass_cnt++;
    ref_rdata = exp_rd;
    @(posedge clk); #1;
    total++;
    if (mem[a[15:2]] !== ref_mem[a[15:2]])
      $display("FAIL %s mem: got %h want %h", name, mem[a[15:2]], ref_mem[a[15:2]]);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; we = 1'b0; mode = '0; uns = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, err, MemWrite} !== 4'b0000 || rdata !== '0 || memAddr !== '0 ||
        memWriteData !== '0 || MemMode !== 2'b00)
      $display("FAIL reset: got busy%b done%b err%b mw%b rdata%h maddr%h mwd%h mm%b want all zero",
               busy, done, err, MemWrite, rdata, memAddr, memWriteData, MemMode);
    else pass_cnt++;
    reset = 1'b0;
    ref_rdata = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_loads();
    preload(16'h1000, 32'h11223344);
    preload(16'h1004, 32'h80FF7F01);
    run_op("ldb_1001", 1'b0, 2'b10, 1'b0, 16'h1001, '0, 1'b0);
    run_op("ldb_1003", 1'b0, 2'b10, 1'b0, 16'h1003, '0, 1'b0);
    run_op("ldh_1004s", 1'b0, 2'b01, 1'b0, 16'h1004, '0, 1'b0);
    run_op("ldh_1004u", 1'b0, 2'b01, 1'b1, 16'h1004, '0, 1'b0);
    run_op("ldb_1006", 1'b0, 2'b10, 1'b0, 16'h1006, '0, 1'b0);
    run_op("ldw_1004", 1'b0, 2'b00, 1'b0, 16'h1004, '0, 1'b0);
    total++;
    if (rdata !== 32'h80FF7F01) $display("FAIL ldw_const: got %h want 80ff7f01", rdata);
    else pass_cnt++;
  endtask

  task automatic test_stores();
    preload(16'h1008, 32'hDEADBEEF);
    run_op("stb_100a", 1'b1, 2'b10, 1'b0, 16'h100A, 32'h000000AA, 1'b0);
    total++;
    if (mem[16'h1008 >> 2] !== 32'hDEADAAEF) $display("FAIL stb_const: got %h want deadaaef", mem[16'h1008 >> 2]);
    else pass_cnt++;
    run_op("stw_100c", 1'b1, 2'b00, 1'b0, 16'h100C, 32'hCAFEBABE, 1'b0);
    run_op("ldh_100e", 1'b0, 2'b01, 1'b1, 16'h100E, '0, 1'b0);
    total++;
    if (rdata !== 32'h0000BABE) $display("FAIL ldh_const: got %h want 0000babe", rdata);
    else pass_cnt++;
    run_op("sth_1008", 1'b1, 2'b01, 1'b0, 16'h1008, 32'h12345678, 1'b0);
  endtask

  task automatic test_misaligned();
    run_op("bad_ldw", 1'b0, 2'b00, 1'b0, 16'h1002, '0, 1'b0);
    run_op("bad_sth", 1'b1, 2'b01, 1'b0, 16'h1001, 32'hFFFF, 1'b0);
    run_op("bad_mode", 1'b1, 2'b11, 1'b0, 16'h1000, 32'h1234, 1'b0);
  endtask

  task automatic test_reset_mid_op();
    int seen_mw;
    preload(16'h1020, 32'h01234567);
    req = 1'b1; we = 1'b1; mode = 2'b10; uns = 1'b0; addr = 16'h1021; wdata = 32'hAA;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    seen_mw = MemWrite;
    reset = 1'b1;
    #1;
    seen_mw = seen_mw + (MemWrite ? 2 : 0);
    total++;
    if (seen_mw != 1) $display("FAIL rst_gate: write-cycle code %0d want 1", seen_mw);
    else pass_cnt++;
    @(posedge clk); #1;
    total++;
    if ({done, busy, MemWrite} !== 3'b000) $display("FAIL rst_idle: done%b busy%b mw%b want 000", done, busy, MemWrite);
    else pass_cnt++;
    reset = 1'b0;
    ref_rdata = '0;
    @(posedge clk); #1;
    total++;
    if (mem[16'h1020 >> 2] !== 32'h01234567) $display("FAIL rst_mem: got %h want 01234567", mem[16'h1020 >> 2]);
    else pass_cnt++;
    run_op("post_rst", 1'b1, 2'b10, 1'b0, 16'h1021, 32'hAA, 1'b0);
  endtask

  task automatic test_back_to_back();
    preload(16'h1040, 32'h0BADF00D);
    preload(16'h1030, 32'h89ABCDEF);
    run_op("busy_req", 1'b0, 2'b10, 1'b1, 16'h1030, '0, 1'b1);
    total++;
    if (mem[16'h1040 >> 2] !== 32'h0BADF00D) $display("FAIL busy_ign: got %h want 0badf00d", mem[16'h1040 >> 2]);
    else pass_cnt++;
    run_op("b2b_1", 1'b1, 2'b01, 1'b0, 16'h1032, 32'h0000BEEF, 1'b0);
    run_op("b2b_2", 1'b0, 2'b00, 1'b0, 16'h1030, '0, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] a;
    for (int i = 0; i < 150; i++) begin
      a = 16'h1000 | 16'($urandom_range(0, 255));
      run_op("rand", 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the multicycle datapath/controller and the external memory subsystem (ROM 0x0xxx, RAM 0x1xxx, I/O 0xFxxx).
- Converts byte, halfword and word load/store requests into aligned word accesses.
- Performs read-modify-write for sub-word stores, and sign- or zero-extension for sub-word loads.
- Flags misaligned or reserved-mode requests without touching memory.

Parameters:
- WIDTH, 32, data width. Only 32 is supported.
- ADDR_WIDTH, 16, byte-address width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  request strobe. Sampled only while busy=0.
- we  input  1  1=store, 0=load. Captured with req.
- mode  input  2  00=word, 01=half, 10=byte, 11=reserved. Captured with req.
- uns  input  1  1=zero-extend loads, 0=sign-extend. Captured with req.
- addr  input  ADDR_WIDTH  byte address. Captured with req.
- wdata  input  WIDTH  store data; low byte/half is used for sub-word stores. Captured with req.
- busy  output  1  high from the cycle after accept until done.
- done  output  1  one-cycle completion pulse.
- err  output  1  high together with done when the request was rejected.
- rdata  output  WIDTH  extended load result. Valid when done=1 for a load; held until the next load completes.
- memAddr  output  ADDR_WIDTH  word-aligned address: {addr[15:2],2'b00}.
- MemWrite  output  1  memory write strobe.
- MemMode  output  2  constant 2'b00 (word access).
- memWriteData  output  WIDTH  merged store word.
- memReadData  input  WIDTH  memory read data; combinational from memAddr.

Behaviour:
- Single clock. Reset is synchronous and active-high. All state is updated on the rising clk edge.
- Reset values: state=IDLE; busy=0, done=0, err=0, rdata=0, MemWrite=0, memAddr=0, memWriteData=0.
- Reset asserted mid-operation:
  - Next edge returns to IDLE; no done pulse is issued.
  - MemWrite is gated by ~reset combinationally, so no write occurs in any cycle where reset=1.
- Accept: in IDLE with req=1, latch we/mode/uns/addr/wdata. req is ignored while busy=1.
- Misalign check at accept:
  - half with addr[0]=1, word with addr[1:0]!=0, or mode=11 → go to DONE with err=1.
  - No memory cycle; rdata unchanged.
- States: IDLE, READ, WRITE, DONE.
  - IDLE→READ: load, or sub-word store.
  - IDLE→WRITE: word store.
  - IDLE→DONE: error.
  - READ→DONE: load. rdata is registered from memReadData at the end of READ.
  - READ→WRITE: sub-word store. The read word is captured into a merge buffer.
  - WRITE→DONE.
  - DONE→IDLE, unconditionally. done=1 for exactly that cycle.
  - busy=1 in READ and WRITE; busy=0 in IDLE and DONE.
  - A new req can be accepted in the cycle after DONE.
- Latency, counted from the accept edge:
  - Load: done in the 2nd cycle after accept.
  - Word store: done in the 2nd cycle.
  - Sub-word store: done in the 3rd cycle.
  - Error: done in the 1st cycle.
- memAddr holds the latched aligned address through READ and WRITE. MemWrite=1 only in WRITE.
- Byte lanes are big-endian: offset 0 → bits[31:24], offset 3 → bits[7:0].
  - Half offset 0 → [31:16]; half offset 2 → [15:0].
- Load extraction:
  - Select the lane by addr[1:0].
  - Extend to 32 bits using the lane MSB when uns=0, zeros when uns=1.
  - Word loads pass through unchanged.
- Store merge: replace only the selected lane of the buffered read word with wdata[7:0] or wdata[15:0]. All other lanes are preserved bit-exact.
- Stores to ROM or I/O regions are issued as normal; memory decides whether to ignore them.

Test Plan:
- RAM[0x1000]=0x11223344. Byte load, addr 0x1001, uns=0 → done in 2nd cycle, rdata=0x00000022, err=0. Same with addr 0x1003 → 0x00000044.
- RAM[0x1004]=0x80FF7F01. Half load 0x1004, uns=0 → 0xFFFF80FF. Same with uns=1 → 0x000080FF. Byte 0x1006, uns=0 → 0x0000007F.
- RAM[0x1008]=0xDEADBEEF. Byte store wdata=0x000000AA to 0x100A → single MemWrite pulse in 2nd cycle with memWriteData=0xDEADAAEF; done in 3rd cycle; readback word=0xDEADAAEF.
- Word store 0xCAFEBABE to 0x100C → MemWrite in 1st cycle after accept, done in 2nd; half load 0x100E, uns=1 → 0x0000BABE.
- Misaligned: word load 0x1002, half store 0x1001, mode=11 → each gives done=err=1 in 1st cycle, MemWrite never asserted, RAM unchanged, rdata unchanged.
- Reset during sub-word store: assert reset in the WRITE cycle → no MemWrite, no done, RAM word unchanged. Next req after reset is accepted and completes normally.
